// File: rtl/sseg_scan_decoder.sv
// Display-scan monitor: recovers the four characters and decimal points
// from a multiplexed active-low 7-segment bus and publishes whole frames.
module sseg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    input  logic        dp,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic [3:0]  blank_mask,
    output logic [3:0]  dp_mask,
    output logic        frame_valid,
    output logic        err_an,
    output logic        err_seg
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] L_MAX = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] L_CAP = CW'(SETTLE_CYCLES - 1);

    logic [11:0]   r_sample;
    logic [CW-1:0] r_cnt;

    logic [15:0]   r_shadow;
    logic [3:0]    r_sh_blank;
    logic [3:0]    r_sh_dp;
    logic [3:0]    r_seen;

    logic [15:0]   r_digits;
    logic [3:0]    r_blank;
    logic [3:0]    r_dpm;
    logic          r_frame_valid;
    logic          r_err_an;
    logic          r_err_seg;

    logic [11:0]   w_in;
    logic          w_same;
    logic          w_cap;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic [3:0]    w_low;
    logic          w_gap;
    logic          w_onehot;
    logic          w_multi;
    logic [5:0]    w_dec;
    logic          w_dec_ok;
    logic          w_dec_blank;
    logic [3:0]    w_dec_val;
    logic [3:0]    w_we;
    logic          w_publish;
    logic          w_err_an_set;
    logic          w_err_seg_set;

    // Result packed as {ok, blank, value}.
    function automatic logic [5:0] f_decode(input logic [6:0] p);
        case (p)
            7'h40:   f_decode = {2'b10, 4'h0};
            7'h79:   f_decode = {2'b10, 4'h1};
            7'h24:   f_decode = {2'b10, 4'h2};
            7'h30:   f_decode = {2'b10, 4'h3};
            7'h19:   f_decode = {2'b10, 4'h4};
            7'h12:   f_decode = {2'b10, 4'h5};
            7'h02:   f_decode = {2'b10, 4'h6};
            7'h78:   f_decode = {2'b10, 4'h7};
            7'h00:   f_decode = {2'b10, 4'h8};
            7'h10:   f_decode = {2'b10, 4'h9};
            7'h08:   f_decode = {2'b10, 4'hA};
            7'h03:   f_decode = {2'b10, 4'hB};
            7'h46:   f_decode = {2'b10, 4'hC};
            7'h21:   f_decode = {2'b10, 4'hD};
            7'h06:   f_decode = {2'b10, 4'hE};
            7'h0E:   f_decode = {2'b10, 4'hF};
            7'h7F:   f_decode = {2'b11, 4'h0};
            default: f_decode = 6'b00_0000;
        endcase
    endfunction

    assign w_in   = {an, sseg, dp};
    assign w_same = (w_in == r_sample);

    // Fires once per stable period, on the edge the count would reach SETTLE_CYCLES.
    assign w_cap  = w_same && (r_cnt == L_CAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sample <= '1;
            r_cnt    <= '0;
        end else begin
            r_sample <= w_in;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != L_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_an  = r_sample[11:8];
    assign w_seg = r_sample[7:1];
    assign w_dp  = r_sample[0];
    assign w_low = ~w_an;

    assign w_gap    = (w_low == 4'd0);
    assign w_onehot = !w_gap && ((w_low & (w_low - 4'd1)) == 4'd0);
    assign w_multi  = !w_gap && !w_onehot;

    assign w_dec       = f_decode(w_seg);
    assign w_dec_ok    = w_dec[5];
    assign w_dec_blank = w_dec[4];
    assign w_dec_val   = w_dec[3:0];

    assign w_we = (w_cap && w_onehot && w_dec_ok) ? w_low : 4'd0;

    assign w_err_an_set  = w_cap && w_multi;
    assign w_err_seg_set = w_cap && w_onehot && !w_dec_ok;

    assign w_publish = (r_seen == 4'hF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow      <= '0;
            r_sh_blank    <= '0;
            r_sh_dp       <= '0;
            r_seen        <= '0;
            r_digits      <= '0;
            r_blank       <= '0;
            r_dpm         <= '0;
            r_frame_valid <= 1'b0;
            r_err_an      <= 1'b0;
            r_err_seg     <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_we[i]) begin
                    r_shadow[4*i +: 4] <= w_dec_val;
                    r_sh_blank[i]      <= w_dec_blank;
                    r_sh_dp[i]         <= ~w_dp;
                end
            end
            r_seen        <= (w_publish ? 4'd0 : r_seen) | w_we;
            r_frame_valid <= w_publish;
            if (w_publish) begin
                r_digits <= r_shadow;
                r_blank  <= r_sh_blank;
                r_dpm    <= r_sh_dp;
            end
            // A new error in the clearing edge keeps the flag set.
            r_err_an  <= w_err_an_set  | (r_err_an  & ~err_clr);
            r_err_seg <= w_err_seg_set | (r_err_seg & ~err_clr);
        end
    end

    assign digits      = r_digits;
    assign blank_mask  = r_blank;
    assign dp_mask     = r_dpm;
    assign frame_valid = r_frame_valid;
    assign err_an      = r_err_an;
    assign err_seg     = r_err_seg;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: scan-level reference model feeding a
// per-cycle scoreboard, directed scan scenarios and random scans.
module tb_sseg_scan_decoder;

    localparam int ST = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic        frame_valid;
    logic        err_an;
    logic        err_seg;

    sseg_scan_decoder #(.SETTLE_CYCLES(ST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .sseg        (sseg),
        .dp          (dp),
        .err_clr     (err_clr),
        .digits      (digits),
        .blank_mask  (blank_mask),
        .dp_mask     (dp_mask),
        .frame_valid (frame_valid),
        .err_an      (err_an),
        .err_seg     (err_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fv;
        logic [15:0] dig;
        logic [3:0]  blk;
        logic [3:0]  dpm;
        logic        ea;
        logic        es;
    } cyc_t;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  blk;
        logic [3:0]  dpm;
    } frm_t;

    cyc_t cq[$];
    frm_t fq[$];

    int total   = 0;
    int bad     = 0;
    int nframes = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: run length of identical samples plus frame bookkeeping.
    logic [11:0] m_prev;
    int          m_run;
    logic [3:0]  m_seen;
    logic [15:0] m_sh;
    logic [3:0]  m_shb;
    logic [3:0]  m_shd;
    logic [15:0] m_dig;
    logic [3:0]  m_blk;
    logic [3:0]  m_dpm;
    logic        m_ea;
    logic        m_es;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [6:0] p, output bit ok,
                                   output bit bl, output logic [3:0] v);
        ok = 0;
        bl = 0;
        v  = 4'h0;
        if (p == 7'h7F) begin
            ok = 1;
            bl = 1;
        end
        for (int k = 0; k < 16; k++) begin
            if (tbl[k] == p) begin
                ok = 1;
                v  = 4'(k);
            end
        end
    endfunction

    task automatic step(input logic [3:0] a, input logic [6:0] s,
                        input logic d, input logic c, input logic r);
        cyc_t        e;
        frm_t        f;
        logic [11:0] smp;
        int          nz;
        int          slot;
        bit          ok;
        bit          bl;
        logic [3:0]  v;
        logic        sa;
        logic        ss;
        an      = a;
        sseg    = s;
        dp      = d;
        err_clr = c;
        rst_n   = r;
        e.fv    = 1'b0;
        if (!r) begin
            m_prev = 12'hFFF;
            m_run  = 1;
            m_seen = 0;
            m_sh   = 0;
            m_shb  = 0;
            m_shd  = 0;
            m_dig  = 0;
            m_blk  = 0;
            m_dpm  = 0;
            m_ea   = 0;
            m_es   = 0;
        end else begin
            smp = {a, s, d};
            if (smp == m_prev) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_prev = smp;
            sa = 0;
            ss = 0;
            if (m_seen == 4'hF) begin
                e.fv   = 1'b1;
                m_dig  = m_sh;
                m_blk  = m_shb;
                m_dpm  = m_shd;
                f.dig  = m_sh;
                f.blk  = m_shb;
                f.dpm  = m_shd;
                fq.push_back(f);
                m_seen = 0;
            end
            // Captured once the same sample has been seen on ST+1 edges in a row.
            if (m_run == ST + 1) begin
                nz   = 0;
                slot = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!a[i]) begin
                        nz++;
                        slot = i;
                    end
                end
                if (nz == 1) begin
                    lookup(s, ok, bl, v);
                    if (ok) begin
                        m_sh[4*slot +: 4] = v;
                        m_shb[slot]       = bl;
                        m_shd[slot]       = ~d;
                        m_seen[slot]      = 1'b1;
                    end else begin
                        ss = 1;
                    end
                end else if (nz > 1) begin
                    sa = 1;
                end
            end
            m_ea = sa | (m_ea & ~c);
            m_es = ss | (m_es & ~c);
        end
        e.dig = m_dig;
        e.blk = m_blk;
        e.dpm = m_dpm;
        e.ea  = m_ea;
        e.es  = m_es;
        cq.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s,
                        input logic d, input int n);
        for (int i = 0; i < n; i++) step(a, s, d, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
    endtask

    cyc_t mon_e;
    frm_t mon_f;

    always @(posedge clk) begin
        #1;
        if (cq.size() != 0) begin
            mon_e = cq.pop_front();
            chk("frame_valid", 32'(frame_valid), 32'(mon_e.fv));
            chk("digits", 32'(digits), 32'(mon_e.dig));
            chk("blank_mask", 32'(blank_mask), 32'(mon_e.blk));
            chk("dp_mask", 32'(dp_mask), 32'(mon_e.dpm));
            chk("err_an", 32'(err_an), 32'(mon_e.ea));
            chk("err_seg", 32'(err_seg), 32'(mon_e.es));
            if (frame_valid) begin
                nframes++;
                if (fq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_pulse: got unexpected pulse, expected none at %0t", $time);
                end else begin
                    mon_f = fq.pop_front();
                    chk("frame_digits", 32'(digits), 32'(mon_f.dig));
                    chk("frame_blank", 32'(blank_mask), 32'(mon_f.blk));
                    chk("frame_dp", 32'(dp_mask), 32'(mon_f.dpm));
                end
            end
        end
    end

    int         f0;
    int         slot;
    int         kind;
    logic [3:0] ra;
    logic [6:0] rs;
    logic       rd;

    initial begin
        an      = 4'hF;
        sseg    = 7'h7F;
        dp      = 1'b1;
        err_clr = 1'b0;
        rst_n   = 1'b0;

        do_reset(2);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_errs", 32'({err_an, err_seg}), 32'h0);

        // Basic scan 1,2,3,4.
        f0 = nframes;
        hold(4'b1110, 7'h79, 1'b1, 8);
        hold(4'b1101, 7'h24, 1'b1, 8);
        hold(4'b1011, 7'h30, 1'b1, 8);
        hold(4'b0111, 7'h19, 1'b1, 8);
        chk("t1_frames", 32'(nframes - f0), 32'd1);
        chk("t1_digits", 32'(digits), 32'h4321);
        chk("t1_masks", 32'({blank_mask, dp_mask}), 32'h00);

        // Blank digit 2 and dp on digit 1.
        f0 = nframes;
        hold(4'b1110, 7'h79, 1'b1, 8);
        hold(4'b1101, 7'h24, 1'b0, 8);
        hold(4'b1011, 7'h7F, 1'b1, 8);
        hold(4'b0111, 7'h19, 1'b1, 8);
        chk("t2_frames", 32'(nframes - f0), 32'd1);
        chk("t2_digits", 32'(digits), 32'h4021);
        chk("t2_blank", 32'(blank_mask), 32'b0100);
        chk("t2_dp", 32'(dp_mask), 32'b0010);

        // Settle boundary, with blank gaps between slots.
        do_reset(1);
        f0 = nframes;
        hold(4'b1101, 7'h12, 1'b1, 8);
        hold(4'hF, 7'h7F, 1'b1, 6);
        hold(4'b1011, 7'h02, 1'b1, 8);
        hold(4'hF, 7'h7F, 1'b1, 6);
        hold(4'b0111, 7'h78, 1'b1, 8);
        hold(4'hF, 7'h7F, 1'b1, 6);
        hold(4'b1110, 7'h00, 1'b1, ST);
        hold(4'hF, 7'h7F, 1'b1, 4);
        chk("t3_short", 32'(nframes - f0), 32'd0);
        hold(4'b1110, 7'h00, 1'b1, ST + 1);
        hold(4'hF, 7'h7F, 1'b1, 4);
        chk("t3_settled", 32'(nframes - f0), 32'd1);
        chk("t3_digits", 32'(digits), 32'h7658);

        // Error flags.
        hold(4'b1100, 7'h40, 1'b1, 6);
        chk("t4_err_an", 32'(err_an), 32'd1);
        hold(4'b1110, 7'h55, 1'b1, 6);
        chk("t4_err_seg", 32'(err_seg), 32'd1);
        step(4'hF, 7'h7F, 1'b1, 1'b1, 1'b1);
        chk("t4_clr", 32'({err_an, err_seg}), 32'h0);
        hold(4'b1110, 7'h55, 1'b1, ST);
        step(4'b1110, 7'h55, 1'b1, 1'b1, 1'b1);
        chk("t4_clr_vs_set", 32'({err_an, err_seg}), 32'h1);

        // Reset discards a partial frame.
        step(4'hF, 7'h7F, 1'b1, 1'b1, 1'b1);
        hold(4'b1110, 7'h30, 1'b1, 8);
        hold(4'b1101, 7'h30, 1'b1, 8);
        hold(4'b1011, 7'h30, 1'b1, 8);
        do_reset(1);
        f0 = nframes;
        hold(4'b1110, 7'h10, 1'b1, 8);
        hold(4'b1101, 7'h00, 1'b1, 8);
        hold(4'b1011, 7'h78, 1'b1, 8);
        hold(4'b0111, 7'h02, 1'b1, 8);
        chk("t5_frames", 32'(nframes - f0), 32'd1);
        chk("t5_digits", 32'(digits), 32'h6789);
        f0 = nframes;
        repeat (3) begin
            hold(4'b1110, 7'h40, 1'b1, 6);
            hold(4'b1101, 7'h40, 1'b1, 6);
            hold(4'b1011, 7'h40, 1'b1, 6);
            hold(4'b0111, 7'h40, 1'b1, 6);
        end
        chk("t5_cont_frames", 32'(nframes - f0), 32'd3);
        chk("t5_cont_digits", 32'(digits), 32'h0000);

        // Random scans against the model.
        repeat (200) begin
            slot = $urandom_range(0, 3);
            kind = $urandom_range(0, 15);
            ra   = ~(4'b0001 << slot);
            rd   = 1'($urandom);
            rs   = tbl[$urandom_range(0, 15)];
            if (kind == 0) ra = ~(4'b0011 << $urandom_range(0, 2));
            if (kind == 1) rs = 7'h55;
            if (kind == 2) rs = 7'h7F;
            for (int i = 0; i < int'($urandom_range(2, 8)); i++)
                step(ra, rs, rd, ($urandom_range(0, 9) == 0), 1'b1);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                step(4'hF, 7'h7F, 1'b1, ($urandom_range(0, 9) == 0), 1'b1);
            if ($urandom_range(0, 49) == 0) do_reset(1);
        end

        hold(4'hF, 7'h7F, 1'b1, 3);
        chk("drain", 32'(cq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
